// File: rtl/alu_chk_pkg.sv
// rtl/alu_chk_pkg.sv - shared constants and types for the ALU response checkers
// Contents:
//   DEFAULT_WIDTH      default operand/result width
//   FLAG_OF/CARY/EQ    bit positions inside the packed {of, cary, eq} flag vector
//   chk_state_t        checker FSM state encoding
//   pack_flags()       builds the packed flag vector from the three flag bits
package alu_chk_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam int FLAG_OF   = 2;
    localparam int FLAG_CARY = 1;
    localparam int FLAG_EQ   = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_REPORT = 2'd3
    } chk_state_t;

    function automatic logic [2:0] pack_flags(
        input logic of_f,
        input logic cary_f,
        input logic eq_f
    );
        logic [2:0] f;
        f            = '0;
        f[FLAG_OF]   = of_f;
        f[FLAG_CARY] = cary_f;
        f[FLAG_EQ]   = eq_f;
        return f;
    endfunction

endpackage

// File: rtl/not_alu_golden.sv
// rtl/not_alu_golden.sv - combinational golden model of the NOT-ALU operation
// Ports:
//   a          operand applied to the ALU
//   exp_s      expected result (~a)
//   exp_flags  expected {of, cary, eq}; of and cary are never set by NOT
module not_alu_golden
    import alu_chk_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] exp_s,
    output logic [2:0]       exp_flags
);

    always_comb begin
        exp_s              = ~a;
        exp_flags          = '0;
        exp_flags[FLAG_EQ] = (exp_s == '0);
    end

endmodule

// File: rtl/alu_resp_checker.sv
// rtl/alu_resp_checker.sv - response checker for the NOT-ALU self-test path
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   in_valid, in_ready      handshake for the tuple a, s, of, cary, eq
//   end_test                single-cycle pulse: no more vectors follow
//   clear                   synchronous clear of counters, capture regs and FSM
//   pass_cnt, fail_cnt      saturating match / mismatch counters
//   err                     sticky mismatch flag
//   first_a/s/flags         first failing vector
//   report_valid, report_ack final report handshake
module alu_resp_checker
    import alu_chk_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] s,
    input  logic             of,
    input  logic             cary,
    input  logic             eq,
    input  logic             end_test,
    input  logic             clear,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             err,
    output logic [WIDTH-1:0] first_a,
    output logic [WIDTH-1:0] first_s,
    output logic [2:0]       first_flags,
    output logic             report_valid,
    input  logic             report_ack
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    chk_state_t state;
    chk_state_t state_nxt;

    logic             xfer;
    logic             pipe_empty;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_s;
    logic [2:0]       s1_flags;

    logic             s2_valid;
    logic             s2_match;
    logic [WIDTH-1:0] s2_a;
    logic [WIDTH-1:0] s2_s;
    logic [2:0]       s2_flags;

    logic [WIDTH-1:0] exp_s;
    logic [2:0]       exp_flags;

    assign in_ready     = (state == ST_IDLE) || (state == ST_RUN);
    assign report_valid = (state == ST_REPORT);

    // clear wins over a simultaneous handshake, so the tuple is dropped
    assign xfer       = in_valid && in_ready && !clear;
    assign pipe_empty = !s1_valid && !s2_valid;

    not_alu_golden #(
        .WIDTH (WIDTH)
    ) u_golden (
        .a         (s1_a),
        .exp_s     (exp_s),
        .exp_flags (exp_flags)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_RUN: begin
                if (end_test) begin
                    // a vector arriving with end_test still has to drain
                    state_nxt = (xfer || !pipe_empty) ? ST_DRAIN : ST_REPORT;
                end else if (xfer) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (pipe_empty) begin
                    state_nxt = ST_REPORT;
                end
            end
            ST_REPORT: begin
                if (report_ack) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (clear) begin
            state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else if (clear) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            s1_valid <= xfer;
            s2_valid <= s1_valid;
        end
    end

    // Data stages are qualified by the valid bits and need no reset.
    always_ff @(posedge clk) begin
        if (xfer) begin
            s1_a     <= a;
            s1_s     <= s;
            s1_flags <= pack_flags(of, cary, eq);
        end
        if (s1_valid) begin
            s2_a     <= s1_a;
            s2_s     <= s1_s;
            s2_flags <= s1_flags;
            s2_match <= (s1_s == exp_s) && (s1_flags == exp_flags);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt    <= '0;
            fail_cnt    <= '0;
            err         <= 1'b0;
            first_a     <= '0;
            first_s     <= '0;
            first_flags <= '0;
        end else if (clear) begin
            pass_cnt    <= '0;
            fail_cnt    <= '0;
            err         <= 1'b0;
            first_a     <= '0;
            first_s     <= '0;
            first_flags <= '0;
        end else if (s2_valid) begin
            if (s2_match) begin
                if (pass_cnt != CNT_MAX) begin
                    pass_cnt <= pass_cnt + CNT_ONE;
                end
            end else begin
                if (fail_cnt != CNT_MAX) begin
                    fail_cnt <= fail_cnt + CNT_ONE;
                end
                // err is still set when fail_cnt is already saturated
                err <= 1'b1;
                if (!err) begin
                    first_a     <= s2_a;
                    first_s     <= s2_s;
                    first_flags <= s2_flags;
                end
            end
        end
    end

endmodule
